axi_mem_responder: RTL

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

---
 rtl/axi_mem_responder.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_responder.sv
// AXI slave backed by an internal word memory; independent write (AW/W/B) and read (AR/R) FSMs.
// Define AXI_MEM_RESPONDER_DECERR_EN to answer out-of-range beats with DECERR instead of OKAY.
module axi_mem_responder #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_WORDS      = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
  input  logic [7:0]                  aw_len,
  input  logic [1:0]                  aw_burst,
  input  logic                        aw_valid,
  output logic                        aw_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
  input  logic                        w_last,
  input  logic                        w_valid,
  output logic                        w_ready,
  output logic [AXI_ID_WIDTH-1:0]     b_id,
  output logic [1:0]                  b_resp,
  output logic                        b_valid,
  input  logic                        b_ready,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
  input  logic [7:0]                  ar_len,
  input  logic [1:0]                  ar_burst,
  input  logic                        ar_valid,
  output logic                        ar_ready,
  output logic [AXI_ID_WIDTH-1:0]     r_id,
  output logic [AXI_DATA_WIDTH-1:0]   r_data,
  output logic [1:0]                  r_resp,
  output logic                        r_last,
  output logic                        r_valid,
  input  logic                        r_ready
);

  localparam int WA    = AXI_ADDR_WIDTH - 2;
  localparam int IW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int BYTES = AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
`ifdef AXI_MEM_RESPONDER_DECERR_EN
  localparam logic [1:0] RESP_OOR = 2'b11;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{aw_addr[1:0], ar_addr[1:0]};

  // ---------------- write path ----------------
  w_state_t                w_state, w_next;
  logic [AXI_ID_WIDTH-1:0] w_id_q;
  logic [WA-1:0]           w_addr_q;
  logic [7:0]              w_len_q, w_cnt;
  logic [1:0]              w_burst_q, b_resp_q;
  logic                    w_err_q, w_oor_q;
  logic                    aw_fire, w_fire, w_is_last, w_addr_oor, beat_err, w_we;

  assign aw_ready   = (w_state == W_IDLE);
  assign w_ready    = (w_state == W_DATA);
  assign b_valid    = (w_state == W_RESP);
  assign b_id       = w_id_q;
  assign b_resp     = b_resp_q;
  assign aw_fire    = aw_valid && aw_ready;
  assign w_fire     = w_valid && w_ready;
  assign w_is_last  = (w_cnt == w_len_q);
  assign w_addr_oor = 64'(w_addr_q) >= 64'(MEM_WORDS);
  // beat count drives sequencing; a disagreeing w_last only poisons the response
  assign beat_err   = w_burst_q[1] || (w_last != w_is_last);
  assign w_we       = w_fire && !w_burst_q[1] && !w_addr_oor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_valid) w_next = W_DATA;
      W_DATA:  if (w_valid && w_is_last) w_next = W_RESP;
      W_RESP:  if (b_ready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_burst_q <= '0;
      w_cnt     <= '0;
      w_err_q   <= 1'b0;
      w_oor_q   <= 1'b0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      if (aw_fire) begin
        w_id_q    <= aw_id;
        w_addr_q  <= aw_addr[AXI_ADDR_WIDTH-1:2];
        w_len_q   <= aw_len;
        w_burst_q <= aw_burst;
        w_cnt     <= '0;
        w_err_q   <= 1'b0;
        w_oor_q   <= 1'b0;
      end
      if (w_fire) begin
        w_cnt   <= w_cnt + 8'd1;
        w_err_q <= w_err_q || beat_err;
        w_oor_q <= w_oor_q || w_addr_oor;
        if (w_burst_q == BURST_INCR) w_addr_q <= w_addr_q + WA'(1);
        if (w_is_last)
          b_resp_q <= (w_err_q || beat_err)    ? RESP_SLVERR :
                      (w_oor_q || w_addr_oor)  ? RESP_OOR    : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we)
      for (int b = 0; b < BYTES; b++)
        if (w_strb[b]) mem[w_addr_q[IW-1:0]][8*b +: 8] <= w_data[8*b +: 8];
  end

  // ---------------- read path ----------------
  r_state_t                  r_state, r_next;
  logic [AXI_ID_WIDTH-1:0]   r_id_q;
  logic [WA-1:0]             r_addr_q, rd_src_addr;
  logic [7:0]                r_len_q, r_cnt, rd_src_len, rd_cnt_nxt;
  logic [1:0]                r_burst_q, rd_src_burst, r_resp_q;
  logic [AXI_DATA_WIDTH-1:0] r_data_q, rd_word;
  logic                      r_last_q, ar_fire, r_fire, rd_load, rd_oor, rd_bad;

  assign ar_ready = (r_state == R_IDLE);
  assign r_valid  = (r_state == R_DATA);
  assign r_id     = r_id_q;
  assign r_data   = r_data_q;
  assign r_resp   = r_resp_q;
  assign r_last   = r_last_q;
  assign ar_fire  = ar_valid && ar_ready;
  assign r_fire   = r_valid && r_ready;
  // next beat is fetched on the AR handshake or when the current beat is accepted
  assign rd_load  = ar_fire || (r_fire && !r_last_q);

  always_comb begin
    rd_src_addr  = ar_addr[AXI_ADDR_WIDTH-1:2];
    rd_src_burst = ar_burst;
    rd_src_len   = ar_len;
    rd_cnt_nxt   = '0;
    if (r_state == R_DATA) begin
      rd_src_addr  = (r_burst_q == BURST_INCR) ? r_addr_q + WA'(1) : r_addr_q;
      rd_src_burst = r_burst_q;
      rd_src_len   = r_len_q;
      rd_cnt_nxt   = r_cnt + 8'd1;
    end
  end

  assign rd_oor  = 64'(rd_src_addr) >= 64'(MEM_WORDS);
  assign rd_bad  = rd_src_burst[1];
  assign rd_word = mem[rd_src_addr[IW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_valid) r_next = R_DATA;
      R_DATA:  if (r_ready && r_last_q) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_cnt     <= '0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
      r_last_q  <= 1'b0;
    end else begin
      if (ar_fire) begin
        r_id_q    <= ar_id;
        r_len_q   <= ar_len;
        r_burst_q <= ar_burst;
      end
      if (rd_load) begin
        r_addr_q <= rd_src_addr;
        r_cnt    <= rd_cnt_nxt;
        r_data_q <= (rd_bad || rd_oor) ? '0 : rd_word;
        r_resp_q <= rd_bad ? RESP_SLVERR : (rd_oor ? RESP_OOR : RESP_OKAY);
        r_last_q <= (rd_cnt_nxt == rd_src_len);
      end else if (r_fire) begin
        r_last_q <= 1'b0;
      end
    end
  end

endmodule
